// File: rtl/note_fetch_sub_if.sv
// Chart-memory read port and matcher-facing note port of note_fetch_sub.
// The module side uses modport master; the memory/matcher side uses slave.
interface note_fetch_sub_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4
);
  logic                    mem_rd;
  logic [ADDR_W-1:0]       mem_addr;
  logic [23:0]             mem_data;
  logic                    note_request;
  logic [17:0]             note_time;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output mem_rd, mem_addr, note_time, fifo_count,
    input  mem_data, note_request
  );

  modport slave (
    input  mem_rd, mem_addr, note_time, fifo_count,
    output mem_data, note_request
  );
endinterface

// File: rtl/note_fetch_sub.sv
// Per-lane note supplier: walks the chart, keeps this lane's notes in a FIFO for the matcher.
// Define NOTE_ORDER_CHECK_EN to drop out-of-order notes and flag order_error.
module note_fetch_sub #(
  parameter int unsigned LANE        = 0,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  note_fetch_sub_if.master bus,
  output logic             song_done,
  output logic             order_error
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StEval, StDone} state_e;

  state_e            state_q, state_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              song_done_q, song_done_d;
  logic [2:0]        lat_q, lat_d;
  logic [17:0]       fifo_q [DEPTH];
  logic [17:0]       fifo_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push, pop;
  logic              lane_hit;
  logic              unused_mask_bits;

`ifdef NOTE_ORDER_CHECK_EN
  logic [17:0]       last_q, last_d;
  logic              order_error_q, order_error_d;
`endif

  assign lane_hit         = bus.mem_data[18+LANE];
  assign unused_mask_bits = ^bus.mem_data[22:18];

  always_comb begin
    state_d     = state_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    song_done_d = song_done_q;
    lat_d       = lat_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    push        = 1'b0;
    pop         = bus.note_request && (count_q != '0);
`ifdef NOTE_ORDER_CHECK_EN
    last_d        = last_q;
    order_error_d = order_error_q;
`endif

    unique case (state_q)
      StIdle: ;
      StIssue: begin
        // Only one read is ever in flight and ISSUE is entered after it retires,
        // so reserving its slot reduces to requiring a free entry now.
        if (count_q < CntW'(DEPTH)) begin
          mem_rd_d = 1'b1;
          lat_d    = '0;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (lat_q == 3'(MEM_LATENCY - 1)) begin
          state_d = StEval;
        end else begin
          lat_d = lat_q + 3'(1);
        end
      end
      StEval: begin
        if (bus.mem_data[23]) begin
          song_done_d = 1'b1;
          state_d     = StDone;
        end else begin
          if (lane_hit) begin
`ifdef NOTE_ORDER_CHECK_EN
            if (bus.mem_data[17:0] < last_q) begin
              order_error_d = 1'b1;
            end else begin
              push   = 1'b1;
              last_d = bus.mem_data[17:0];
            end
`else
            push = 1'b1;
`endif
          end
          if (&mem_addr_q) begin
            song_done_d = 1'b1;
            state_d     = StDone;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = StIssue;
          end
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = bus.mem_data[17:0];
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: ;
    endcase

    // Restart from any state; an in-flight read is orphaned because lat/state restart.
    if (start) begin
      state_d     = StIssue;
      mem_rd_d    = 1'b0;
      mem_addr_d  = '0;
      song_done_d = 1'b0;
      lat_d       = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
`ifdef NOTE_ORDER_CHECK_EN
      last_d        = '0;
      order_error_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      song_done_q <= 1'b0;
      lat_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
`ifdef NOTE_ORDER_CHECK_EN
      last_q        <= '0;
      order_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      song_done_q <= song_done_d;
      lat_q       <= lat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_q      <= fifo_d;
`ifdef NOTE_ORDER_CHECK_EN
      last_q        <= last_d;
      order_error_q <= order_error_d;
`endif
    end
  end

  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.fifo_count = count_q;
  assign bus.note_time  = (count_q == '0) ? 18'h3FFFF : fifo_q[rd_ptr_q];
  assign song_done      = song_done_q;
`ifdef NOTE_ORDER_CHECK_EN
  assign order_error    = order_error_q;
`else
  assign order_error    = 1'b0;
`endif

endmodule

// File: tb/tb_note_fetch_sub.sv
// Directed bench for note_fetch_sub (LANE=0, DEPTH=4, MEM_LATENCY=2) with a latency-pipelined chart memory.
module tb_note_fetch_sub;
  localparam int unsigned AW  = 12;
  localparam int unsigned DEP = 4;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        song_done;
  logic        order_error;
  int          total = 0;
  int          bad = 0;
  int unsigned rd_cnt = 0;
  int unsigned r0;
  logic [23:0] chart [4096];
  logic [23:0] pipe [LAT];

  note_fetch_sub_if #(.ADDR_W(AW), .DEPTH(DEP)) bus ();

  note_fetch_sub #(
    .LANE(0), .ADDR_W(AW), .DEPTH(DEP), .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .song_done(song_done), .order_error(order_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= (bus.mem_rd === 1'b1) ? chart[bus.mem_addr] : 24'h0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (bus.mem_rd === 1'b1) rd_cnt <= rd_cnt + 1;
  end
  assign bus.mem_data = pipe[LAT-1];

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_chart();
    for (int i = 0; i < 4096; i++) chart[i] = 24'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pop();
    bus.note_request = 1'b1;
    tick();
    bus.note_request = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (song_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 24'(song_done), 24'h1);
  endtask

  task automatic wait_rd(input string tag, input logic [AW-1:0] addr, input int budget);
    int n = 0;
    while (!(bus.mem_rd === 1'b1 && bus.mem_addr === addr) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 24'(bus.mem_rd === 1'b1 && bus.mem_addr === addr), 24'h1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_rd"}, 24'(bus.mem_rd), 24'h0);
    chk({tag, "_mem_addr"}, 24'(bus.mem_addr), 24'h0);
    chk({tag, "_count"}, 24'(bus.fifo_count), 24'h0);
    chk({tag, "_note_time"}, 24'(bus.note_time), 24'h3FFFF);
    chk({tag, "_song_done"}, 24'(song_done), 24'h0);
    chk({tag, "_order_error"}, 24'(order_error), 24'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    start            = 1'b0;
    bus.note_request = 1'b0;
    clear_chart();
    tick(3);
    chk_reset_vals("por");
    reset = 1'b0;
    tick();

    // Filtering: 150 belongs to lane 1, end marker at address 3.
    chart[0] = 24'h040064;
    chart[1] = 24'h080096;
    chart[2] = 24'h0400C8;
    chart[3] = 24'h800000;
    r0 = rd_cnt;
    pulse_start();
    wait_done("t1_done", 100);
    tick(5);
    chk("t1_reads", 24'(rd_cnt - r0), 24'd4);
    chk("t1_head", 24'(bus.note_time), 24'd100);
    chk("t1_count", 24'(bus.fifo_count), 24'd2);

    // Pops: head valid during the request cycle, advances next cycle.
    bus.note_request = 1'b1;
    chk("t2_head_in_req", 24'(bus.note_time), 24'd100);
    tick();
    bus.note_request = 1'b0;
    chk("t2_head1", 24'(bus.note_time), 24'd200);
    chk("t2_count1", 24'(bus.fifo_count), 24'd1);
    tick(3);
    pop();
    chk("t2_head2", 24'(bus.note_time), 24'h3FFFF);
    chk("t2_count2", 24'(bus.fifo_count), 24'd0);
    pop();
    chk("t2_empty_pop_count", 24'(bus.fifo_count), 24'd0);
    chk("t2_empty_pop_head", 24'(bus.note_time), 24'h3FFFF);

    // Back-pressure: 10 entries, FIFO holds 4, reads stall.
    clear_chart();
    for (int i = 0; i < 10; i++) chart[i] = 24'h040000 | 24'((i + 1) * 10);
    chart[10] = 24'h800000;
    r0 = rd_cnt;
    pulse_start();
    tick(60);
    chk("t3_count_full", 24'(bus.fifo_count), 24'd4);
    chk("t3_reads_stall", 24'(rd_cnt - r0), 24'd4);
    chk("t3_head", 24'(bus.note_time), 24'd10);
    chk("t3_not_done", 24'(song_done), 24'h0);
    pop();
    tick(30);
    chk("t3_reads_after_pop", 24'(rd_cnt - r0), 24'd5);
    chk("t3_head_after_pop", 24'(bus.note_time), 24'd20);
    chk("t3_count_after_pop", 24'(bus.fifo_count), 24'd4);

    // Pop request on empty FIFO coincides with the EVAL push of 300.
    clear_chart();
    chart[0] = 24'h04012C;
    chart[1] = 24'h800000;
    pulse_start();
    wait_rd("t4_rd0", 12'd0, 20);
    tick(LAT);
    chk("t4_empty_count", 24'(bus.fifo_count), 24'd0);
    chk("t4_empty_head", 24'(bus.note_time), 24'h3FFFF);
    pop();
    chk("t4_count", 24'(bus.fifo_count), 24'd1);
    chk("t4_head", 24'(bus.note_time), 24'd300);
    wait_done("t4_done", 40);

    // Restart during WAIT of address 5; its data (555) must be discarded.
    clear_chart();
    for (int i = 0; i < 4; i++) chart[i] = 24'h080000 | 24'(i + 1);
    chart[4] = 24'h04002C;
    chart[5] = 24'h04022B;
    chart[6] = 24'h800000;
    pulse_start();
    wait_rd("t5_rd5", 12'd5, 60);
    chk("t5_pre_count", 24'(bus.fifo_count), 24'd1);
    tick();
    start    = 1'b1;
    chart[0] = 24'h800000;
    tick();
    start = 1'b0;
    chk("t5_cleared_count", 24'(bus.fifo_count), 24'd0);
    r0 = rd_cnt;
    wait_rd("t5_rd0", 12'd0, 20);
    tick(10);
    chk("t5_done", 24'(song_done), 24'h1);
    chk("t5_count", 24'(bus.fifo_count), 24'd0);
    chk("t5_head", 24'(bus.note_time), 24'h3FFFF);
    chk("t5_reads", 24'(rd_cnt - r0), 24'd1);

    // Reset during WAIT of address 1.
    clear_chart();
    chart[0] = 24'h040007;
    chart[1] = 24'h040008;
    chart[2] = 24'h800000;
    pulse_start();
    wait_rd("t6_rd1", 12'd1, 30);
    chk("t6_pre_count", 24'(bus.fifo_count), 24'd1);
    tick();
    reset = 1'b1;
    tick();
    chk_reset_vals("t6_rst");
    reset = 1'b0;
    r0 = rd_cnt;
    tick(10);
    chk("t6_idle_reads", 24'(rd_cnt - r0), 24'd0);
    chk("t6_idle_count", 24'(bus.fifo_count), 24'd0);

    // Ordering: 500, 400, 600.
    clear_chart();
    chart[0] = 24'h0401F4;
    chart[1] = 24'h040190;
    chart[2] = 24'h040258;
    chart[3] = 24'h800000;
    pulse_start();
    wait_done("t7_done", 50);
    tick(2);
`ifdef NOTE_ORDER_CHECK_EN
    chk("t7_order_error", 24'(order_error), 24'h1);
    chk("t7_count", 24'(bus.fifo_count), 24'd2);
    chk("t7_head0", 24'(bus.note_time), 24'd500);
    pop();
    chk("t7_head1", 24'(bus.note_time), 24'd600);
    pop();
    chk("t7_head2", 24'(bus.note_time), 24'h3FFFF);
`else
    chk("t7_order_error", 24'(order_error), 24'h0);
    chk("t7_count", 24'(bus.fifo_count), 24'd3);
    chk("t7_head0", 24'(bus.note_time), 24'd500);
    pop();
    chk("t7_head1", 24'(bus.note_time), 24'd400);
    pop();
    chk("t7_head2", 24'(bus.note_time), 24'd600);
    pop();
    chk("t7_head3", 24'(bus.note_time), 24'h3FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
